// File: rtl/gemm_pkg.sv
// Shared types for the GEMM tile sequencer.
// States, error codes and the latched job configuration.
package gemm_pkg;

  localparam int SYS_ROW    = 4;
  localparam int SYS_COL    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 8;
  localparam int ACCUM_ADDR = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_LOAD_W,
    S_FILL,
    S_COMPUTE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_STEP,
    S_FINISH
  } sched_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CFG     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] m;
    logic [DATA_WIDTH-1:0] k_tiles;
    logic [DATA_WIDTH-1:0] n_tiles;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [ADDR_WIDTH-1:0] in_base;
    logic [ACCUM_ADDR-1:0] acc_base;
  } tile_cfg_t;

endpackage

// File: rtl/gemm_tile_sched_addr.sv
// Tile address generator: weight, input and accumulator bases.
// Registers the bases when the sequencer enters CLR or LOAD_W.
module tile_addr_gen
  import gemm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_clr_i,
  input  logic                  ld_w_i,
  input  logic [DATA_WIDTH-1:0] n_i,
  input  logic [DATA_WIDTH-1:0] k_i,
  input  logic [DATA_WIDTH-1:0] m_i,
  input  logic [DATA_WIDTH-1:0] k_tiles_i,
  input  logic [ADDR_WIDTH-1:0] w_base_i,
  input  logic [ADDR_WIDTH-1:0] in_base_i,
  input  logic [ACCUM_ADDR-1:0] acc_base_i,
  output logic [ADDR_WIDTH-1:0] w_addr_o,
  output logic [ADDR_WIDTH-1:0] in_addr_o,
  output logic [ACCUM_ADDR-1:0] acc_addr_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0] n_w, k_w, m_w, kt_w;
  logic [PW-1:0] w_off, in_off, acc_off;

  assign n_w  = PW'(n_i);
  assign k_w  = PW'(k_i);
  assign m_w  = PW'(m_i);
  assign kt_w = PW'(k_tiles_i);

  assign w_off   = (n_w * kt_w + k_w) * PW'(SYS_ROW);
  assign in_off  = k_w * m_w;
  assign acc_off = n_w * m_w;

  // Wrap-around of the bases is intended.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr_o   <= '0;
      in_addr_o  <= '0;
      acc_addr_o <= '0;
    end else begin
      if (ld_clr_i)
        acc_addr_o <= ACCUM_ADDR'(PW'(acc_base_i) + acc_off);
      if (ld_w_i) begin
        w_addr_o  <= ADDR_WIDTH'(PW'(w_base_i) + w_off);
        in_addr_o <= ADDR_WIDTH'(PW'(in_base_i) + in_off);
      end
    end
  end

endmodule

// File: rtl/gemm_tile_sched.sv
// Tile sequencer for the systolic GEMM datapath.
// Walks the N x K weight-tile grid and paces fill, compute and drain.
module gemm_tile_sched
  import gemm_pkg::*;
#(
  parameter int FILL_LAT = 5,
  parameter int TIMEOUT  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] cfg_m,
  input  logic [DATA_WIDTH-1:0] cfg_k_tiles,
  input  logic [DATA_WIDTH-1:0] cfg_n_tiles,
  input  logic [ADDR_WIDTH-1:0] cfg_w_base,
  input  logic [ADDR_WIDTH-1:0] cfg_in_base,
  input  logic [ACCUM_ADDR-1:0] cfg_acc_base,
  input  logic                  sys_done,
  output logic                  fifo_in_en,
  output logic [ADDR_WIDTH-1:0] w_base_addr,
  output logic [ADDR_WIDTH-1:0] in_base_addr,
  output logic                  compute_en,
  output logic [DATA_WIDTH-1:0] num_row,
  output logic                  weight_fill,
  output logic                  weight_change,
  output logic [ACCUM_ADDR-1:0] accum_wr_addr,
  output logic                  accum_clr,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  sched_state_e          state_q, state_d;
  tile_cfg_t             cfg_q, cfg_d;
  logic [DATA_WIDTH-1:0] n_q, n_d, k_q, k_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            err_q, err_d;
  logic                  ld_clr, ld_w;
  logic [DATA_WIDTH:0]   k_inc, n_inc;
  logic                  cfg_bad;

  assign k_inc   = {1'b0, k_q} + (DATA_WIDTH+1)'(1);
  assign n_inc   = {1'b0, n_q} + (DATA_WIDTH+1)'(1);
  assign cfg_bad = (cfg_m == '0) || (cfg_k_tiles == '0) ||
                   (cfg_n_tiles == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      n_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      n_q     <= n_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    n_d     = n_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ld_clr  = 1'b0;
    ld_w    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          cfg_d = '{m: cfg_m, k_tiles: cfg_k_tiles,
                    n_tiles: cfg_n_tiles, w_base: cfg_w_base,
                    in_base: cfg_in_base, acc_base: cfg_acc_base};
          n_d   = '0;
          k_d   = '0;
          err_d = ERR_NONE;
          if (cfg_bad) begin
            err_d   = ERR_CFG;
            state_d = S_FINISH;
          end else begin
            ld_clr  = 1'b1;
            state_d = S_CLR;
          end
        end
      end
      S_CLR: begin
        ld_w    = 1'b1;
        state_d = S_LOAD_W;
      end
      S_LOAD_W: begin
        cnt_d   = '0;
        state_d = S_FILL;
      end
      S_FILL: begin
        if (cnt_q == CW'(FILL_LAT - 1))
          state_d = S_COMPUTE;
        else
          cnt_d = cnt_q + CW'(1);
      end
      S_COMPUTE: begin
        cnt_d   = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI, S_WAIT_LO: begin
        // Watchdog spans both wait states.
        if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (state_q == S_WAIT_HI && sys_done)
            state_d = S_WAIT_LO;
          if (state_q == S_WAIT_LO && !sys_done)
            state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (k_inc < {1'b0, cfg_q.k_tiles}) begin
          k_d     = k_inc[DATA_WIDTH-1:0];
          ld_w    = 1'b1;
          state_d = S_LOAD_W;
        end else begin
          k_d = '0;
          if (n_inc < {1'b0, cfg_q.n_tiles}) begin
            n_d     = n_inc[DATA_WIDTH-1:0];
            ld_clr  = 1'b1;
            state_d = S_CLR;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      ld_clr  = 1'b0;
      ld_w    = 1'b0;
      err_d   = err_q;
    end
  end

  tile_addr_gen u_addr (
    .clk        (clk),
    .rst        (rst),
    .ld_clr_i   (ld_clr),
    .ld_w_i     (ld_w),
    .n_i        (n_d),
    .k_i        (k_d),
    .m_i        (cfg_d.m),
    .k_tiles_i  (cfg_d.k_tiles),
    .w_base_i   (cfg_d.w_base),
    .in_base_i  (cfg_d.in_base),
    .acc_base_i (cfg_d.acc_base),
    .w_addr_o   (w_base_addr),
    .in_addr_o  (in_base_addr),
    .acc_addr_o (accum_wr_addr)
  );

  assign fifo_in_en    = (state_q == S_LOAD_W);
  assign compute_en    = (state_q == S_COMPUTE);
  assign num_row       = compute_en ? cfg_q.m : '0;
  assign weight_change = compute_en;
  assign weight_fill   = compute_en && (n_q == '0) && (k_q == '0);
  assign accum_clr     = (state_q == S_CLR);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FINISH);
  assign err           = err_q;

endmodule
